fifo_req_1r1w: RTL

//  Parametrised FIFO with one write, one read and one request port per cycle.

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/fifo_ptr.sv | 27 ++
 rtl/fifo_req_1r1w.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Purpose: shared FIFO helpers (pointer width, depth legality, full compare, occupancy).
// Latency: n/a, constant and combinational functions only.
// Backpressure: n/a.
//
// Pointers are passed zero-extended to fifo_ptr_t so one set of functions
// serves every DEPTH up to FIFO_MAX_DEPTH. The caller supplies the index width aw.
package fifo_pkg;

   localparam int FIFO_MAX_DEPTH = 64;
   localparam int FIFO_PTR_MAX_W = 7;   // $clog2(FIFO_MAX_DEPTH) + 1

   typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

   // Pointer width for a given depth: index bits plus one wrap bit.
   function automatic int FIFO_PTR_W(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Legal depths are powers of two in 2..FIFO_MAX_DEPTH.
   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && (depth <= FIFO_MAX_DEPTH) && ((depth & (depth - 1)) == 0);
   endfunction

   // Full when the indices match and the wrap bits differ.
   function automatic logic fifo_is_full(input fifo_ptr_t wr, input fifo_ptr_t rd, input int aw);
      fifo_ptr_t idx_mask;
      fifo_ptr_t wrap_mask;
      idx_mask  = fifo_ptr_t'((1 << aw) - 1);
      wrap_mask = fifo_ptr_t'(1 << aw);
      return ((wr & idx_mask) == (rd & idx_mask)) && (((wr ^ rd) & wrap_mask) != '0);
   endfunction

   // Occupancy wr - rd, modulo 2^(aw+1) so pointer wrap-around is transparent.
   function automatic fifo_ptr_t fifo_occupancy(input fifo_ptr_t wr, input fifo_ptr_t rd, input int aw);
      fifo_ptr_t ptr_mask;
      ptr_mask = fifo_ptr_t'((1 << (aw + 1)) - 1);
      return (wr - rd) & ptr_mask;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Purpose: one FIFO pointer, W bits including the wrap bit.
// Latency: new value visible one cycle after inc/clr.
// Backpressure: none; the caller qualifies inc.
//
// Ports: clk, rst (async active-low), clr (sync clear, wins over inc),
//        inc (advance by one, rolls over at 2^W), ptr (current value).
module fifo_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_req_1r1w.sv
// Purpose: FIFO with push, in-order bus issue (grant) and in-order retire (pop).
// Latency: pushed data visible on req_data/head_data next cycle; reads are 0-cycle from storage.
// Backpressure: push dropped when full, grant dropped without req_vld, pop dropped without head_vld.
//
// Ports: clk, rst (async active-low), flush (sync pointer clear),
//        push/in_data (write), req_gnt (issue), pop (retire),
//        req_data/req_vld (oldest un-issued entry), head_data/head_vld (oldest issued entry),
//        count/full/empty_n (occupancy), almost_full (only with FIFO_ALMOST_FULL_EN).
// Build option: define FIFO_ALMOST_FULL_EN to add AF_LEVEL and the almost_full output.
module fifo_req_1r1w
   import fifo_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 8,
`ifdef FIFO_ALMOST_FULL_EN
   parameter  int AF_LEVEL = DEPTH - 2,
`endif
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] in_data,
   input  logic             req_gnt,
   input  logic             pop,
   output logic [WIDTH-1:0] req_data,
   output logic             req_vld,
   output logic [WIDTH-1:0] head_data,
   output logic             head_vld,
   output logic [AW:0]      count,
   output logic             full,
`ifdef FIFO_ALMOST_FULL_EN
   output logic             almost_full,
`endif
   output logic             empty_n
);

   localparam int PW = FIFO_PTR_W(DEPTH);

   if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
      $error("fifo_req_1r1w: DEPTH must be a power of 2 in 2..64");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    req_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             gnt_ok;
   logic             pop_ok;
   logic [DEPTH-1:0] wr_sel;
   logic [WIDTH-1:0] mem [DEPTH];

   // Qualifiers look only at the current state, so a push into a full FIFO is
   // rejected even when a pop frees a slot in the same cycle.
   assign push_ok = push & ~full;
   assign gnt_ok  = req_gnt & req_vld;
   assign pop_ok  = pop & head_vld;

   fifo_ptr #(.W(PW)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push_ok),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.W(PW)) u_req_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (gnt_ok),
      .ptr (req_ptr)
   );

   fifo_ptr #(.W(PW)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop_ok),
      .ptr (rd_ptr)
   );

   // One-hot write select; flush suppresses the write along with the pointer moves.
   always_comb begin
      wr_sel = '0;
      wr_sel[wr_ptr[AW-1:0]] = push_ok & ~flush;
   end

   // Storage is cleared only by reset; flush leaves stale data behind the pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               mem[i] <= in_data;
            end
         end
      end
   end

   assign req_data  = mem[req_ptr[AW-1:0]];
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Full-width compares keep valid flags correct when two pointers share an index.
   assign req_vld  = (wr_ptr != req_ptr);
   assign head_vld = (req_ptr != rd_ptr);
   assign full     = fifo_is_full(fifo_ptr_t'(wr_ptr), fifo_ptr_t'(rd_ptr), AW);
   assign count    = PW'(fifo_occupancy(fifo_ptr_t'(wr_ptr), fifo_ptr_t'(rd_ptr), AW));
   assign empty_n  = (count != '0);

`ifdef FIFO_ALMOST_FULL_EN
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] rd_nxt;
   logic [PW-1:0] count_nxt;

   assign wr_nxt    = wr_ptr + PW'(push_ok);
   assign rd_nxt    = rd_ptr + PW'(pop_ok);
   assign count_nxt = PW'(fifo_occupancy(fifo_ptr_t'(wr_nxt), fifo_ptr_t'(rd_nxt), AW));

   // Registered from the next-state occupancy so it lines up with count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         almost_full <= 1'b0;
      end else if (flush) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (int'(count_nxt) >= AF_LEVEL);
      end
   end
`endif

endmodule
